// File: rtl/c499_lock_pkg.sv
// Shared widths, CRC constants and FSM encoding for the c499 key loader slice.
package c499_lock_pkg;
  localparam int X_W   = 42;
  localparam int P_W   = 4;
  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
  localparam int KEY_W  = X_W + P_W;
  localparam int CNT_W  = $clog2(KEY_W);
  localparam int FAIL_W = 2;

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, EVAL, LOCKED} state_e;

  // Saturating increment for the failure counter.
  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v,
                                                input logic [FAIL_W-1:0] top);
    return (v >= top) ? top : v + FAIL_W'(1);
  endfunction
endpackage

// File: rtl/c499_key_loader_if.sv
// Serial key-load bus between the key source and the c499 key loader.
interface c499_key_loader_if;
  import c499_lock_pkg::*;
  logic              start;
  logic              sdi;
  logic              sdi_valid;
  logic              sdi_ready;
  logic [X_W-1:0]    key_x;
  logic [P_W-1:0]    key_p;
  logic              key_valid;
  logic              busy;
  logic              done;
  logic              err;
  logic [FAIL_W-1:0] fail_cnt;
  logic              locked;

  modport master (
    output start, sdi, sdi_valid,
    input  sdi_ready, key_x, key_p, key_valid, busy, done, err, fail_cnt, locked
  );
  modport slave (
    input  start, sdi, sdi_valid,
    output sdi_ready, key_x, key_p, key_valid, busy, done, err, fail_cnt, locked
  );
endinterface

// File: rtl/crc_serial.sv
// Bit-serial CRC, MSB first, zero init, no reflection or final XOR.
module crc_serial #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   POLY = 8'h07
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] crc
);
  logic fb;
  assign fb = crc[W-1] ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= '0;
    else if (clr) crc <= '0;
    else if (en)  crc <= {crc[W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end
endmodule

// File: rtl/c499_key_loader.sv
// Receives the 46-bit c499 unlock key plus CRC-8, commits it on a CRC match,
// and locks out permanently after MAX_FAIL consecutive bad loads.
module c499_key_loader
  import c499_lock_pkg::*;
#(
  parameter int MAX_FAIL = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  c499_key_loader_if.slave   bus
);
  localparam logic [FAIL_W-1:0] MAX_F = FAIL_W'(MAX_FAIL);

  state_e            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [KEY_W-1:0]  shadow;
  logic [CRC_W-1:0]  rx_crc;
  logic [CRC_W-1:0]  calc_crc;
  logic [FAIL_W-1:0] fail_nxt;
  logic              xfer;

  assign bus.sdi_ready = (state == SHIFT) || (state == CHECK);
  assign bus.busy      = (state != IDLE) && (state != LOCKED);
  assign bus.locked    = (state == LOCKED);
  assign xfer          = bus.sdi_valid && bus.sdi_ready;
  assign fail_nxt      = sat_inc(bus.fail_cnt, MAX_F);

  // Only key bits feed the CRC; the received CRC bits go to rx_crc instead.
  crc_serial #(.W(CRC_W), .POLY(CRC_POLY)) u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == IDLE) && bus.start),
    .en    (xfer && (state == SHIFT)),
    .din   (bus.sdi),
    .crc   (calc_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shadow        <= '0;
      rx_crc        <= '0;
      bus.key_x     <= '0;
      bus.key_p     <= '0;
      bus.key_valid <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.fail_cnt  <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (xfer) begin
            shadow <= {shadow[KEY_W-2:0], bus.sdi};
            if (bit_cnt == CNT_W'(KEY_W-1)) begin
              bit_cnt <= '0;
              state   <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            rx_crc <= {rx_crc[CRC_W-2:0], bus.sdi};
            if (bit_cnt == CNT_W'(CRC_W-1)) begin
              bit_cnt <= '0;
              state   <= EVAL;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        EVAL: begin
          if (calc_crc == rx_crc) begin
            bus.key_p     <= shadow[KEY_W-1 -: P_W];
            bus.key_x     <= shadow[X_W-1:0];
            bus.key_valid <= 1'b1;
            bus.fail_cnt  <= '0;
            bus.done      <= 1'b1;
            state         <= IDLE;
          end else begin
            bus.fail_cnt <= fail_nxt;
            bus.err      <= 1'b1;
            // Lockout scrubs the committed key so the core sees no usable key.
            if (fail_nxt == MAX_F) begin
              state         <= LOCKED;
              bus.key_x     <= '0;
              bus.key_p     <= '0;
              bus.key_valid <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        LOCKED:  state <= LOCKED;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c499_key_loader.sv
// Directed bench for c499_key_loader: good/bad loads, stalls, lockout, async reset.
module tb_c499_key_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  c499_key_loader_if bus();

  c499_key_loader #(.MAX_FAIL(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [3:0]  KP1 = 4'hA;
  localparam logic [41:0] KX1 = 42'h2A5C3C39669;
  localparam logic [3:0]  KP2 = 4'h5;
  localparam logic [41:0] KX2 = 42'h1F00DBEEF01;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [45:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 45; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic do_load(input logic [45:0] key, input logic [7:0] crc, input bit stall,
                         input int mid_start, output int lat, output bit got_done,
                         output bit got_err);
    logic [53:0] stream;
    int t0;
    bit rdy_bad;
    stream  = {key, crc};
    rdy_bad = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t0 = cyc;
    for (int i = 53; i >= 0; i--) begin
      if (stall) begin
        bus.sdi_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.sdi       = stream[i];
      bus.sdi_valid = 1'b1;
      if (53 - i == mid_start) bus.start = 1'b1;
      @(negedge clk);
      if (!bus.sdi_ready && !rdy_bad) begin
        rdy_bad = 1'b1;
        chk("ready_during_load", {63'd0, bus.sdi_ready}, 64'd1);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.sdi_valid = 1'b0;
    got_done = 1'b0;
    got_err  = 1'b0;
    lat      = -1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.err) begin
        got_done = bus.done;
        got_err  = bus.err;
        lat      = cyc - t0;
        break;
      end
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_key_x"},     64'(bus.key_x), 64'd0);
    chk({tag, "_key_p"},     64'(bus.key_p), 64'd0);
    chk({tag, "_key_valid"}, 64'(bus.key_valid), 64'd0);
    chk({tag, "_sdi_ready"}, 64'(bus.sdi_ready), 64'd0);
    chk({tag, "_busy"},      64'(bus.busy), 64'd0);
    chk({tag, "_done"},      64'(bus.done), 64'd0);
    chk({tag, "_err"},       64'(bus.err), 64'd0);
    chk({tag, "_fail_cnt"},  64'(bus.fail_cnt), 64'd0);
    chk({tag, "_locked"},    64'(bus.locked), 64'd0);
  endtask

  initial begin
    int lat;
    bit gd, ge;
    bus.start = 1'b0; bus.sdi = 1'b0; bus.sdi_valid = 1'b0;
    #3;
    chk_idle_reset("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero key, zero CRC, no stalls.
    do_load(46'd0, 8'h00, 1'b0, -1, lat, gd, ge);
    chk("zero_done", 64'(gd), 64'd1);
    chk("zero_err", 64'(ge), 64'd0);
    chk("zero_latency", 64'(lat), 64'd55);
    chk("zero_key_x", 64'(bus.key_x), 64'd0);
    chk("zero_key_p", 64'(bus.key_p), 64'd0);
    chk("zero_key_valid", 64'(bus.key_valid), 64'd1);
    chk("zero_fail_cnt", 64'(bus.fail_cnt), 64'd0);
    @(posedge clk); #1;
    chk("zero_done_width", 64'(bus.done), 64'd0);

    // Known key with sdi_valid low every other cycle.
    do_load({KP1, KX1}, crc8({KP1, KX1}), 1'b1, -1, lat, gd, ge);
    chk("stall_done", 64'(gd), 64'd1);
    chk("stall_latency", 64'(lat), 64'd109);
    chk("stall_key_p", 64'(bus.key_p), 64'(KP1));
    chk("stall_key_x", 64'(bus.key_x), 64'(KX1));
    chk("stall_busy_after", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk("stall_done_width", 64'(bus.done), 64'd0);

    // Bad CRC keeps the committed key.
    do_load(46'd0, 8'h01, 1'b0, -1, lat, gd, ge);
    chk("bad1_err", 64'(ge), 64'd1);
    chk("bad1_done", 64'(gd), 64'd0);
    chk("bad1_fail_cnt", 64'(bus.fail_cnt), 64'd1);
    chk("bad1_key_x", 64'(bus.key_x), 64'(KX1));
    chk("bad1_key_p", 64'(bus.key_p), 64'(KP1));
    chk("bad1_key_valid", 64'(bus.key_valid), 64'd1);
    @(posedge clk); #1;
    chk("bad1_err_width", 64'(bus.err), 64'd0);

    do_load({KP2, KX2}, crc8({KP2, KX2}) ^ 8'h80, 1'b0, -1, lat, gd, ge);
    chk("bad2_fail_cnt", 64'(bus.fail_cnt), 64'd2);
    chk("bad2_locked", 64'(bus.locked), 64'd0);
    do_load(46'd0, 8'h01, 1'b0, -1, lat, gd, ge);
    chk("bad3_err", 64'(ge), 64'd1);
    chk("lock_fail_cnt", 64'(bus.fail_cnt), 64'd3);
    chk("lock_locked", 64'(bus.locked), 64'd1);
    chk("lock_key_x", 64'(bus.key_x), 64'd0);
    chk("lock_key_p", 64'(bus.key_p), 64'd0);
    chk("lock_key_valid", 64'(bus.key_valid), 64'd0);
    chk("lock_sdi_ready", 64'(bus.sdi_ready), 64'd0);

    // Start and data while locked are ignored.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.sdi_valid = 1'b1;
    bus.sdi = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.sdi_valid = 1'b0;
    chk("lock_hold_locked", 64'(bus.locked), 64'd1);
    chk("lock_hold_busy", 64'(bus.busy), 64'd0);
    chk("lock_hold_sdi_ready", 64'(bus.sdi_ready), 64'd0);
    chk("lock_hold_fail_cnt", 64'(bus.fail_cnt), 64'd3);
    rst_n = 1'b0;
    #2;
    chk_idle_reset("unlock_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two failures then a good load clears the count.
    do_load(46'd0, 8'h01, 1'b0, -1, lat, gd, ge);
    do_load(46'd0, 8'h01, 1'b0, -1, lat, gd, ge);
    chk("recov_pre_fail_cnt", 64'(bus.fail_cnt), 64'd2);
    do_load({KP2, KX2}, crc8({KP2, KX2}), 1'b0, -1, lat, gd, ge);
    chk("recov_done", 64'(gd), 64'd1);
    chk("recov_fail_cnt", 64'(bus.fail_cnt), 64'd0);
    chk("recov_locked", 64'(bus.locked), 64'd0);
    chk("recov_key_x", 64'(bus.key_x), 64'(KX2));
    chk("recov_key_p", 64'(bus.key_p), 64'(KP2));
    chk("recov_key_valid", 64'(bus.key_valid), 64'd1);

    // Async reset after 20 key bits.
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.sdi_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.sdi = i[0];
      @(posedge clk); #1;
    end
    chk("mid_busy", 64'(bus.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    bus.sdi_valid = 1'b0;
    chk_idle_reset("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full good load with a stray start pulse during SHIFT.
    do_load({KP1, KX1}, crc8({KP1, KX1}), 1'b0, 10, lat, gd, ge);
    chk("after_rst_done", 64'(gd), 64'd1);
    chk("after_rst_err", 64'(ge), 64'd0);
    chk("after_rst_latency", 64'(lat), 64'd55);
    chk("after_rst_key_x", 64'(bus.key_x), 64'(KX1));
    chk("after_rst_key_p", 64'(bus.key_p), 64'(KP1));
    chk("after_rst_key_valid", 64'(bus.key_valid), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/c499_key_loader.md
Name: c499_key_loader

Overview:
- Upstream stage of the locked c499 SEC core: serially receives the 46-bit unlock key (42 XOR key bits X_1..X_42, 4 mux key bits p1..p4) plus an 8-bit CRC.
- Verifies the CRC, then commits the key to a held register that drives the core's key inputs.
- Counts failed loads and enters permanent lockout after MAX_FAIL consecutive failures.

Parameters:
- X_W, 42, number of XOR key bits (key_x width)
- P_W, 4, number of mux key bits (key_p width)
- CRC_W, 8, CRC length following the key bits
- CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1), init 8'h00, no reflection, no final XOR
- MAX_FAIL, 3, consecutive failures that trigger lockout (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE
- sdi  in  1  serial key/CRC data bit
- sdi_valid  in  1  sdi carries a bit this cycle
- sdi_ready  out  1  loader accepts a bit this cycle
- key_x  out  X_W  committed XOR key; key_x[i] drives X_(i+1)
- key_p  out  P_W  committed mux key; key_p[i] drives p(i+1)
- key_valid  out  1  committed key is good
- busy  out  1  state is not IDLE and not LOCKED
- done  out  1  one-cycle pulse: load passed, key committed
- err  out  1  one-cycle pulse: load failed CRC
- fail_cnt  out  2  consecutive failure count, saturates at MAX_FAIL
- locked  out  1  lockout active, sticky until rst_n

Behaviour:
- Reset (async assert, sync release): state IDLE; key_x=0, key_p=0, key_valid=0, sdi_ready=0, busy=0, done=0, err=0, fail_cnt=0, locked=0; shadow key and CRC registers cleared.
- A bit transfers when sdi_valid && sdi_ready on a rising edge. sdi_ready is combinationally 1 exactly in SHIFT and CHECK. sdi_valid without sdi_ready is ignored.
- State machine:
  - IDLE: on start go to SHIFT. Clear the bit counter and CRC register. Do not touch the committed key.
  - SHIFT: accept X_W+P_W = 46 bits, MSB first, into a left-shifting shadow register. Each accepted bit also feeds the serial CRC. After bit 46 go to CHECK.
  - CHECK: accept CRC_W bits, MSB first, into a rx_crc register. After the last bit go to EVAL.
  - EVAL: lasts exactly one cycle and takes no bits. Compare the computed CRC with rx_crc.
    - Match: key_p <= shadow[45:42] (first 4 bits received), key_x <= shadow[41:0], key_valid <= 1, fail_cnt <= 0, done pulse; next state IDLE.
    - Mismatch: key_x, key_p and key_valid are left unchanged, fail_cnt increments (saturating), err pulse. If the new count equals MAX_FAIL, next state is LOCKED; otherwise IDLE.
  - LOCKED: key_x=0, key_p=0, key_valid=0, sdi_ready=0; start is ignored; the only exit is rst_n.
- Latency: done/err assert in the cycle after EVAL, and key outputs update on the same edge. Total time is 46+8 accepted bits plus 1 cycle.
- start while busy is ignored and does not restart the load. Gaps in sdi_valid stall the load indefinitely; there is no timeout.
- Reset asserted mid-load aborts the load immediately and returns every output to its reset value, including the committed key.
- done and err are never high in the same cycle, and each is high for exactly one cycle.

Decomposition:
- Package c499_lock_pkg holds:
  - X_W, P_W, CRC_W, CRC_POLY
  - the state enum {IDLE, SHIFT, CHECK, EVAL, LOCKED}
  - the bit-counter width localparam
- One sub-module, crc_serial, implements the bit-serial CRC.
  - Ports: clk, rst_n, clr, en, din, crc[CRC_W-1:0].
  - Parameters: width and polynomial.

Test Plan:
- Reset, start, 46 zero bits then CRC 8'h00 -> done pulse 55 cycles after start (no stalls); key_x=0, key_p=0, key_valid=1, fail_cnt=0.
- Valid load with a known key, sdi_valid toggling every other cycle -> key_p equals the first 4 bits sent and key_x the next 42; completion is delayed only by the stalls; done fires once.
- 46 zero bits then CRC 8'h01 -> err pulse, fail_cnt=1, key outputs and key_valid unchanged from the previous good load.
- Three consecutive bad loads -> fail_cnt=3, locked=1, key_x=0, key_valid=0, sdi_ready stays 0; a later start and valid stream are ignored until rst_n pulses, which then clears everything.
- Two bad loads then one good load -> fail_cnt returns to 0, locked=0, new key committed.
- rst_n asserted after 20 key bits -> all outputs reset immediately (asynchronously); a following full good load completes normally. A start pulse issued mid-SHIFT does not disturb the load.
